// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port, synchronous-read memory between the
// instruction-fetch path and the load/store path. Data requests normally win
// contention. A streak counter hands fetch the next contended grant after
// DATA_STREAK_MAX consecutive contended data grants.
module memory_arbiter #(
  parameter int READ_LATENCY    = 1,
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_FetchReq,
  input  logic [31:0] i_FetchAddress,
  output logic        o_FetchValid,
  output logic [31:0] o_FetchData,
  input  logic        i_DataReq,
  input  logic        i_DataWrite,
  input  logic [31:0] i_DataAddress,
  input  logic [31:0] i_DataWriteData,
  input  logic [3:0]  i_DataByteEnable,
  output logic        o_DataValid,
  output logic [31:0] o_DataReadData,
  output logic [31:0] o_MemAddress,
  output logic        o_MemWriteEnable,
  output logic [3:0]  o_MemByteEnable,
  output logic [31:0] o_MemDataOut,
  input  logic [31:0] i_MemDataIn,
  output logic        o_Busy
);

  localparam int CntW    = $clog2(READ_LATENCY + 1);
  localparam int StreakW = (DATA_STREAK_MAX < 1) ? 1 : $clog2(DATA_STREAK_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESPOND} stateT;

  stateT              state;
  logic [CntW-1:0]    waitCount;
  logic [StreakW-1:0] streak;
  logic               grantData;
  logic               grantWrite;

  logic contention;
  logic pickData;

  // Data wins unless fetch is also asking and the data streak is exhausted.
  // With DATA_STREAK_MAX=0 the compare is never true, so fetch always wins.
  assign contention = i_FetchReq & i_DataReq;
  assign pickData   = i_DataReq & (~i_FetchReq | (streak < StreakW'(DATA_STREAK_MAX)));

  assign o_Busy = (state != IDLE);

  // Arbiter FSM with registered memory strobes, data captures and valid pulses.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state            <= IDLE;
      waitCount        <= '0;
      streak           <= '0;
      grantData        <= 1'b0;
      grantWrite       <= 1'b0;
      o_FetchValid     <= 1'b0;
      o_FetchData      <= '0;
      o_DataValid      <= 1'b0;
      o_DataReadData   <= '0;
      o_MemAddress     <= '0;
      o_MemWriteEnable <= 1'b0;
      o_MemByteEnable  <= '0;
      o_MemDataOut     <= '0;
    end else begin
      // Pulses and the write strobe last exactly one cycle unless re-set below.
      o_FetchValid     <= 1'b0;
      o_DataValid      <= 1'b0;
      o_MemWriteEnable <= 1'b0;
      case (state)
        IDLE: begin
          if (i_FetchReq || i_DataReq) begin
            state <= ACCESS;
            if (pickData) begin
              grantData        <= 1'b1;
              grantWrite       <= i_DataWrite;
              o_MemAddress     <= i_DataAddress;
              o_MemWriteEnable <= i_DataWrite;
              o_MemByteEnable  <= i_DataByteEnable;
              o_MemDataOut     <= i_DataWriteData;
            end else begin
              grantData        <= 1'b0;
              grantWrite       <= 1'b0;
              o_MemAddress     <= i_FetchAddress;
              o_MemByteEnable  <= 4'hF;
            end
            // Only contended data grants extend the streak; anything else restarts it.
            if (contention && pickData) begin
              streak <= streak + 1'b1;
            end else begin
              streak <= '0;
            end
          end
        end
        ACCESS: begin
          if (grantWrite) begin
            state       <= RESPOND;
            o_DataValid <= 1'b1;
          end else begin
            state     <= WAIT;
            waitCount <= CntW'(READ_LATENCY);
          end
        end
        WAIT: begin
          if (waitCount == CntW'(1)) begin
            state <= RESPOND;
            if (grantData) begin
              o_DataReadData <= i_MemDataIn;
              o_DataValid    <= 1'b1;
            end else begin
              o_FetchData  <= i_MemDataIn;
              o_FetchValid <= 1'b1;
            end
          end else begin
            waitCount <= waitCount - 1'b1;
          end
        end
        RESPOND: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed checks of the memory arbiter with READ_LATENCY=1
// and READ_LATENCY=3 instances, each attached to a small behavioural memory.
module tb_memory_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;

  // Instance with READ_LATENCY=1
  logic        fetchReq1, fetchValid1, dataReq1, dataWrite1, dataValid1, memWe1, busy1;
  logic [31:0] fetchAddr1, fetchData1, dataAddr1, dataWdata1, dataRdata1;
  logic [31:0] memAddr1, memDout1, memDin1;
  logic [3:0]  dataBe1, memBe1;

  // Instance with READ_LATENCY=3
  logic        fetchReq3, fetchValid3, dataReq3, dataWrite3, dataValid3, memWe3, busy3;
  logic [31:0] fetchAddr3, fetchData3, dataAddr3, dataWdata3, dataRdata3;
  logic [31:0] memAddr3, memDout3, memDin3;
  logic [3:0]  dataBe3, memBe3;

  memory_arbiter #(.READ_LATENCY(1), .DATA_STREAK_MAX(4)) u_dut1 (
    .i_Clock(clk), .i_Reset_n(rstN),
    .i_FetchReq(fetchReq1), .i_FetchAddress(fetchAddr1),
    .o_FetchValid(fetchValid1), .o_FetchData(fetchData1),
    .i_DataReq(dataReq1), .i_DataWrite(dataWrite1), .i_DataAddress(dataAddr1),
    .i_DataWriteData(dataWdata1), .i_DataByteEnable(dataBe1),
    .o_DataValid(dataValid1), .o_DataReadData(dataRdata1),
    .o_MemAddress(memAddr1), .o_MemWriteEnable(memWe1), .o_MemByteEnable(memBe1),
    .o_MemDataOut(memDout1), .i_MemDataIn(memDin1), .o_Busy(busy1)
  );

  memory_arbiter #(.READ_LATENCY(3), .DATA_STREAK_MAX(4)) u_dut3 (
    .i_Clock(clk), .i_Reset_n(rstN),
    .i_FetchReq(fetchReq3), .i_FetchAddress(fetchAddr3),
    .o_FetchValid(fetchValid3), .o_FetchData(fetchData3),
    .i_DataReq(dataReq3), .i_DataWrite(dataWrite3), .i_DataAddress(dataAddr3),
    .i_DataWriteData(dataWdata3), .i_DataByteEnable(dataBe3),
    .o_DataValid(dataValid3), .o_DataReadData(dataRdata3),
    .o_MemAddress(memAddr3), .o_MemWriteEnable(memWe3), .o_MemByteEnable(memBe3),
    .o_MemDataOut(memDout3), .i_MemDataIn(memDin3), .o_Busy(busy3)
  );

  // Fixed initial memory image, word-indexed by address bits [9:2].
  function automatic logic [31:0] initWord(input int idx);
    case (idx)
      16:      return 32'hCAFEF00D;  // 0x40
      32:      return 32'h00A00113;  // 0x80
      64:      return 32'h00500093;  // 0x100
      128:     return 32'h11223344;  // 0x200
      default: return 32'h10000000 + 32'(idx);
    endcase
  endfunction

  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] rd3a, rd3b, rd3c;

  // Memory for the latency-1 instance: reloads its image while reset is held.
  always @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < 256; i++) mem1[i] <= initWord(i);
    end else begin
      memDin1 <= mem1[memAddr1[9:2]];
      if (memWe1) begin
        for (int b = 0; b < 4; b++)
          if (memBe1[b]) mem1[memAddr1[9:2]][8*b +: 8] <= memDout1[8*b +: 8];
      end
    end
  end

  // Memory for the latency-3 instance: three-stage read pipeline.
  always @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < 256; i++) mem3[i] <= initWord(i);
    end else begin
      rd3a <= mem3[memAddr3[9:2]];
      rd3b <= rd3a;
      rd3c <= rd3b;
      if (memWe3) begin
        for (int b = 0; b < 4; b++)
          if (memBe3[b]) mem3[memAddr3[9:2]][8*b +: 8] <= memDout3[8*b +: 8];
      end
    end
  end
  assign memDin3 = rd3c;

  int totalCount = 0;
  int badCount   = 0;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  bit expIsData [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    int pulses;
    int firstAt;
    int gap;
    int nGrant;

    rstN = 1'b0;
    fetchReq1 = 0; fetchAddr1 = '0; dataReq1 = 0; dataWrite1 = 0; dataAddr1 = '0; dataWdata1 = '0; dataBe1 = '0;
    fetchReq3 = 0; fetchAddr3 = '0; dataReq3 = 0; dataWrite3 = 0; dataAddr3 = '0; dataWdata3 = '0; dataBe3 = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    checkValue("rst_ctrl", {28'b0, busy1, memWe1, fetchValid1, dataValid1}, 32'h0);
    checkValue("rst_addr", memAddr1, 32'h0);
    checkValue("rst_be_dout", {memBe1, 28'b0} | memDout1, 32'h0);
    checkValue("rst_rdata", fetchData1 | dataRdata1, 32'h0);
    rstN = 1'b1;
    tick();

    // Single fetch at 0x100 (latency 1)
    fetchReq1 = 1; fetchAddr1 = 32'h100;
    tick();  // T+1
    checkValue("fetch_access_addr", memAddr1, 32'h100);
    checkValue("fetch_access_we_be", {27'b0, memWe1, memBe1}, 32'h0F);
    checkValue("fetch_access_busy", {31'b0, busy1}, 32'h1);
    tick();  // T+2
    checkValue("fetch_t2_valid", {31'b0, fetchValid1}, 32'h0);
    tick();  // T+3
    checkValue("fetch_t3_valid", {31'b0, fetchValid1}, 32'h1);
    checkValue("fetch_t3_data", fetchData1, 32'h00500093);
    fetchReq1 = 0;
    tick();
    checkValue("fetch_done_idle", {30'b0, busy1, fetchValid1}, 32'h0);

    // Store 0xDEADBEEF to 0x200 with BE=0011
    dataReq1 = 1; dataWrite1 = 1; dataAddr1 = 32'h200; dataWdata1 = 32'hDEADBEEF; dataBe1 = 4'b0011;
    tick();  // T+1
    checkValue("store_t1_we_be", {27'b0, memWe1, memBe1}, 32'h13);
    checkValue("store_t1_addr", memAddr1, 32'h200);
    checkValue("store_t1_dout", memDout1, 32'hDEADBEEF);
    tick();  // T+2
    checkValue("store_t2_we_valid", {30'b0, memWe1, dataValid1}, 32'h1);
    checkValue("store_rdata_kept", dataRdata1, 32'h0);
    dataReq1 = 0; dataWrite1 = 0;
    tick();

    // Load back 0x200: only the low two byte lanes were written
    dataReq1 = 1; dataAddr1 = 32'h200;
    tick();  // T+1
    checkValue("load_t1_we", {31'b0, memWe1}, 32'h0);
    tick();  // T+2
    tick();  // T+3
    checkValue("load_t3_valid", {31'b0, dataValid1}, 32'h1);
    checkValue("load_t3_data", dataRdata1, 32'h1122BEEF);
    dataReq1 = 0;
    tick();

    // Fetch held through RESPOND: back-to-back fetches, pulses 4 cycles apart
    fetchReq1 = 1; fetchAddr1 = 32'h100;
    pulses = 0; firstAt = 0; gap = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (fetchValid1) begin
        pulses++;
        if (pulses == 1) firstAt = c;
        else begin
          gap = c - firstAt;
          fetchReq1 = 0;
          break;
        end
      end
    end
    checkValue("held_fetch_pulses", 32'(pulses), 32'd2);
    checkValue("held_fetch_gap", 32'(gap), 32'd4);
    tick();
    tick();

    // Contention with both requests held: D,D,D,D,F,D,D,D,D,F
    fetchReq1 = 1; fetchAddr1 = 32'h100;
    dataReq1 = 1; dataWrite1 = 0; dataAddr1 = 32'h204;
    nGrant = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (fetchValid1 || dataValid1) begin
        checkValue($sformatf("grant%0d_is_data", nGrant), {31'b0, dataValid1}, {31'b0, expIsData[nGrant]});
        nGrant++;
        if (nGrant == 10) begin
          fetchReq1 = 0; dataReq1 = 0;
          break;
        end
      end
    end
    checkValue("grant_count", 32'(nGrant), 32'd10);
    tick();
    tick();

    // Latency 3: load 0x40 with a simultaneous fetch of 0x80
    dataReq3 = 1; dataWrite3 = 0; dataAddr3 = 32'h40;
    fetchReq3 = 1; fetchAddr3 = 32'h80;
    tick(); tick(); tick(); tick();  // T+4
    checkValue("rl3_t4_valid", {30'b0, dataValid3, fetchValid3}, 32'h0);
    tick();  // T+5
    checkValue("rl3_t5_valid", {30'b0, dataValid3, fetchValid3}, 32'h2);
    checkValue("rl3_t5_data", dataRdata3, 32'hCAFEF00D);
    dataReq3 = 0;
    tick();  // T+6 IDLE
    checkValue("rl3_t6_busy", {31'b0, busy3}, 32'h0);
    tick();  // T+7 ACCESS for the fetch
    checkValue("rl3_fetch_addr", memAddr3, 32'h80);
    checkValue("rl3_fetch_we_busy", {30'b0, memWe3, busy3}, 32'h1);
    tick(); tick(); tick(); tick();  // T+11
    checkValue("rl3_fetch_valid", {31'b0, fetchValid3}, 32'h1);
    checkValue("rl3_fetch_data", fetchData3, 32'h00A00113);
    fetchReq3 = 0;
    tick();

    // Reset while instance 3 waits on a load and instance 1 is mid-store
    dataReq3 = 1; dataAddr3 = 32'h40;
    tick();  // T+1
    tick();  // T+2
    dataReq1 = 1; dataWrite1 = 1; dataAddr1 = 32'h300; dataWdata1 = 32'h01020304; dataBe1 = 4'hF;
    tick();  // T+3: instance 3 in WAIT, instance 1 in ACCESS
    checkValue("pre_rst_busy3", {31'b0, busy3}, 32'h1);
    checkValue("pre_rst_we1", {31'b0, memWe1}, 32'h1);
    #2;
    rstN = 1'b0;
    dataReq3 = 0; dataReq1 = 0; dataWrite1 = 0;
    #1;
    checkValue("async_rst_busy", {30'b0, busy3, busy1}, 32'h0);
    checkValue("async_rst_we1", {31'b0, memWe1}, 32'h0);
    checkValue("async_rst_rdata3", dataRdata3, 32'h0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (dataValid3 || fetchValid3 || dataValid1 || fetchValid1) pulses++;
    end
    checkValue("post_rst_no_valid", 32'(pulses), 32'd0);

    // Reissued load completes normally
    dataReq3 = 1; dataAddr3 = 32'h40;
    tick(); tick(); tick(); tick(); tick();  // T+5
    checkValue("reissue_valid", {31'b0, dataValid3}, 32'h1);
    checkValue("reissue_data", dataRdata3, 32'hCAFEF00D);
    dataReq3 = 0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares one single-port, synchronous-read memory between the CPU instruction-fetch path and the load/store path. This replaces the separate instruction and data memory instances.
- Each requester uses a req/valid handshake. Arbitration is data-priority, with a starvation guard for fetch.
- Sits between program_counter/cpu fetch logic, the load/store unit and the single memory instance.

Parameters:
- READ_LATENCY, 1: cycles from the memory sampling an address to i_MemDataIn being valid (minimum 1).
- DATA_STREAK_MAX, 4: maximum consecutive data grants won while fetch is also requesting. When the streak counter equals this value, fetch wins the next contention. A value of 0 means fetch always wins contention.

Ports:
- i_Clock  in  1  clock, rising edge
- i_Reset_n  in  1  asynchronous, active-low reset
- i_FetchReq  in  1  fetch request; held until o_FetchValid
- i_FetchAddress  in  32  fetch byte address; stable while i_FetchReq=1
- o_FetchValid  out  1  one-cycle pulse; o_FetchData valid
- o_FetchData  out  32  fetched instruction word
- i_DataReq  in  1  data request; held until o_DataValid
- i_DataWrite  in  1  1=store, 0=load; stable with i_DataReq
- i_DataAddress  in  32  data byte address
- i_DataWriteData  in  32  store data
- i_DataByteEnable  in  4  store byte lanes
- o_DataValid  out  1  one-cycle pulse; load data valid or store complete
- o_DataReadData  out  32  load result
- o_MemAddress  out  32  memory address
- o_MemWriteEnable  out  1  memory write strobe
- o_MemByteEnable  out  4  memory byte lanes
- o_MemDataOut  out  32  memory write data
- i_MemDataIn  in  32  memory read data
- o_Busy  out  1  arbiter not IDLE

Behaviour:
- Clock and reset: single clock i_Clock. i_Reset_n is asynchronous and active-low.
- Reset values: FSM IDLE, streak=0, all o_* = 0.
- Reset mid-operation: the transaction is dropped with no valid pulse, WE drops immediately, and requesters must reissue.
- FSM states: IDLE, ACCESS, WAIT, RESPOND.
- IDLE:
  - Requests are sampled only in IDLE.
  - No request: stay in IDLE.
  - Otherwise, grant one requester and latch address, write flag, byte enables and write data into the o_Mem* registers. Next state is ACCESS.
- Arbitration in IDLE:
  - Only one requester active: it wins.
  - Both active and streak<DATA_STREAK_MAX: data wins and streak increments.
  - Both active and streak==DATA_STREAK_MAX: fetch wins and streak resets to 0.
  - Any grant made without contention resets streak to 0.
- ACCESS (1 cycle):
  - o_Mem* driven. o_MemWriteEnable=1 only for a data store, for exactly this cycle.
  - Fetch drives o_MemByteEnable=4'hF and WE=0.
  - Store: next state RESPOND. Load or fetch: next state WAIT with counter=READ_LATENCY.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, i_MemDataIn is captured into o_FetchData or o_DataReadData (per the granted requester) and the next state is RESPOND.
- RESPOND (1 cycle):
  - The granted requester's valid pulses high; the next state is IDLE.
  - A requester holding req high in the RESPOND cycle is seen in the following IDLE as a new transaction.
- Latency from the request cycle T:
  - Read (fetch or load): valid in cycle T+2+READ_LATENCY.
  - Store: valid in cycle T+2.
  - Throughput is one transaction per 3+READ_LATENCY cycles (reads) or 3 cycles (stores).
- Data output rules:
  - o_FetchData and o_DataReadData hold their value until the next read for that requester. Stores leave o_DataReadData unchanged.
  - o_MemAddress, o_MemByteEnable and o_MemDataOut hold their last value outside ACCESS. o_MemWriteEnable is 0 outside ACCESS.
- Address and byte-enable handling:
  - Addresses pass through unmodified, including misaligned low bits; there is no alignment check.
  - A store with i_DataByteEnable=4'h0 still performs the ACCESS cycle (WE=1, BE=0) and responds normally.
- o_Busy = (state != IDLE).
- Protocol violation: dropping a req before its valid is a violation. The arbiter still completes the transaction and pulses valid.

Test Plan:
- Single fetch, READ_LATENCY=1, addr 0x100, memory word 0x00500093 -> o_MemAddress=0x100, WE=0 in T+1; o_FetchValid=1 with o_FetchData=0x00500093 in T+3.
- Store addr 0x200, data 0xDEADBEEF, BE=4'b0011 -> WE=1 for exactly one cycle (T+1) with BE=0x3; o_DataValid in T+2; o_DataReadData unchanged.
- Fetch and data held continuously with DATA_STREAK_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F; no fetch starved beyond 4 data grants.
- READ_LATENCY=3, load addr 0x40 -> o_DataValid exactly at T+5; a simultaneous fetch is granted in the IDLE cycle after RESPOND.
- i_Reset_n low during WAIT of a load -> all valids 0 and o_Busy=0 asynchronously; no valid pulse after release; a reissued load completes normally.
- Fetch req held high through RESPOND -> second transaction starts in the next IDLE; the two o_FetchValid pulses are 4 cycles apart (READ_LATENCY=1).
